// File: rtl/vid2is_mc_control.sv
// Multi-channel Vid2IS control/status register bank behind one Avalon-MM slave.
// Address is {channel, reg}; channel == NUM_CHANNELS selects the global page.
module vid2is_mc_control #(
  parameter int NUM_CHANNELS      = 2,
  parameter int USED_WORDS_WIDTH  = 15,
  parameter int STD_WIDTH         = 3,
  parameter int H_ACTIVE_PIXELS   = 1920,
  parameter int V_ACTIVE_LINES_F0 = 540,
  parameter int V_ACTIVE_LINES_F1 = 540,
  parameter int INTERLACED        = 1,
  parameter int CHW               = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CHANNELS*USED_WORDS_WIDTH-1:0] usedw,
  input  logic [NUM_CHANNELS-1:0]                overflow_sticky,
  input  logic [NUM_CHANNELS-1:0]                is_output_enable,
  input  logic [NUM_CHANNELS-1:0]                update,
  input  logic [NUM_CHANNELS-1:0]                resolution_change,
  input  logic [NUM_CHANNELS-1:0]                stable,
  input  logic [NUM_CHANNELS-1:0]                interlaced,
  input  logic [NUM_CHANNELS-1:0]                resolution_valid,
  input  logic [NUM_CHANNELS*15-1:0]             active_sample_count,
  input  logic [NUM_CHANNELS*14-1:0]             active_line_count_f0,
  input  logic [NUM_CHANNELS*14-1:0]             active_line_count_f1,
  input  logic [NUM_CHANNELS*15-1:0]             total_sample_count,
  input  logic [NUM_CHANNELS*STD_WIDTH-1:0]      vid_std,
  input  logic [CHW+3:0]                         av_address,
  input  logic                                   av_read,
  input  logic                                   av_write,
  input  logic [15:0]                            av_writedata,
  output logic [15:0]                            av_readdata,
  output logic                                   av_readdatavalid,
  output logic [NUM_CHANNELS-1:0]                enable,
  output logic [NUM_CHANNELS-1:0]                clear_overflow_sticky,
  output logic [NUM_CHANNELS-1:0]                is_interlaced,
  output logic [NUM_CHANNELS*15-1:0]             is_active_sample_count,
  output logic [NUM_CHANNELS*14-1:0]             is_active_line_count_f0,
  output logic [NUM_CHANNELS*14-1:0]             is_active_line_count_f1,
  output logic                                   irq
);
  localparam int N = NUM_CHANNELS;

  logic [CHW-1:0] ch;
  logic [3:0]     rg;
  logic [3:0]     ctrl    [N];
  logic [3:0]     ctrl_nx [N];
  logic [7:0]     cnt     [N];
  logic [14:0]    cap_as  [N];
  logic [14:0]    cap_tot [N];
  logic [13:0]    cap_f0  [N];
  logic [13:0]    cap_f1  [N];
  logic [N-1:0]   cap_stable, cap_valid, cap_il;
  logic [N-1:0]   pend_chg, pend_stb, deferred, clr_ovf;
  logic [N-1:0]   upd_d, rc_d, upd_edge, rc_edge;
  logic [N-1:0]   wr_ch, cap_en, chg_set, stb_set;
  logic [15:0]    rdata;
  logic           unused_wdata;

  assign ch           = av_address[CHW+3:4];
  assign rg           = av_address[3:0];
  assign upd_edge     = update ^ upd_d;
  assign rc_edge      = resolution_change ^ rc_d;
  assign irq          = |(pend_chg | pend_stb);
  assign unused_wdata = ^av_writedata[15:5];

  always_comb begin
    ctrl_nx = ctrl;
    wr_ch   = '0;
    cap_en  = '0;
    chg_set = '0;
    stb_set = '0;
    for (int c = 0; c < N; c++) begin
      wr_ch[c] = av_write && (ch == CHW'(c));
      if (wr_ch[c] && rg == 4'd0) ctrl_nx[c] = av_writedata[3:0];
      // A deferred capture fires on the first cycle freeze is observed low.
      cap_en[c]  = !ctrl[c][3] && (upd_edge[c] || deferred[c]);
      chg_set[c] = rc_edge[c] && ctrl[c][1];
      stb_set[c] = cap_en[c] && ctrl[c][2] && (stable[c] != cap_stable[c]);
    end
  end

  always_ff @(posedge clk) begin
    upd_d <= update;
    rc_d  <= resolution_change;
    if (rst) begin
      pend_chg         <= '0;
      pend_stb         <= '0;
      deferred         <= '0;
      clr_ovf          <= '0;
      cap_stable       <= '0;
      cap_valid        <= '0;
      cap_il           <= {N{INTERLACED != 0}};
      av_readdata      <= '0;
      av_readdatavalid <= 1'b0;
      for (int c = 0; c < N; c++) begin
        ctrl[c]    <= '0;
        cnt[c]     <= '0;
        cap_as[c]  <= 15'(H_ACTIVE_PIXELS);
        cap_f0[c]  <= 14'(V_ACTIVE_LINES_F0);
        cap_f1[c]  <= (INTERLACED != 0) ? 14'(V_ACTIVE_LINES_F1) : 14'd0;
        cap_tot[c] <= '0;
      end
    end else begin
      av_readdatavalid <= av_read;
      if (av_read) av_readdata <= rdata;
      for (int c = 0; c < N; c++) begin
        ctrl[c] <= ctrl_nx[c];
        if (cap_en[c]) begin
          cap_as[c]     <= active_sample_count[c*15 +: 15];
          cap_f0[c]     <= active_line_count_f0[c*14 +: 14];
          cap_f1[c]     <= active_line_count_f1[c*14 +: 14];
          cap_tot[c]    <= total_sample_count[c*15 +: 15];
          cap_stable[c] <= stable[c];
          cap_valid[c]  <= resolution_valid[c];
          cap_il[c]     <= interlaced[c];
          deferred[c]   <= 1'b0;
        end else if (ctrl[c][3] && upd_edge[c]) begin
          deferred[c] <= 1'b1;
        end
        // Set wins over W1C; a cleared enable drops its pending bit.
        pend_chg[c] <= ctrl_nx[c][1] &&
                       (chg_set[c] || (pend_chg[c] && !(wr_ch[c] && rg == 4'd2 && av_writedata[1])));
        pend_stb[c] <= ctrl_nx[c][2] &&
                       (stb_set[c] || (pend_stb[c] && !(wr_ch[c] && rg == 4'd2 && av_writedata[2])));
        if (wr_ch[c] && rg == 4'd9)
          cnt[c] <= {7'd0, rc_edge[c]};
        else if (rc_edge[c] && cnt[c] != 8'hff)
          cnt[c] <= cnt[c] + 8'd1;
        clr_ovf[c] <= ((wr_ch[c] && rg == 4'd1 && av_writedata[4]) || clr_ovf[c]) && overflow_sticky[c];
      end
    end
  end

  always_comb begin
    enable                  = '0;
    is_active_sample_count  = '0;
    is_active_line_count_f0 = '0;
    is_active_line_count_f1 = '0;
    clear_overflow_sticky   = clr_ovf;
    is_interlaced           = cap_il;
    for (int c = 0; c < N; c++) begin
      enable[c]                        = ctrl[c][0];
      is_active_sample_count[c*15 +: 15]  = cap_as[c];
      is_active_line_count_f0[c*14 +: 14] = cap_f0[c];
      is_active_line_count_f1[c*14 +: 14] = cap_f1[c];
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < N; c++) begin
      if (ch == CHW'(c)) begin
        case (rg)
          4'd0:    rdata = {12'd0, ctrl[c]};
          4'd1:    rdata = {11'd0, overflow_sticky[c], cap_valid[c], cap_il[c], cap_stable[c], is_output_enable[c]};
          4'd2:    rdata = {13'd0, pend_stb[c], pend_chg[c], 1'b0};
          4'd3:    rdata = 16'(usedw[c*USED_WORDS_WIDTH +: USED_WORDS_WIDTH]);
          4'd4:    rdata = {1'b0, cap_as[c]};
          4'd5:    rdata = {2'd0, cap_f0[c]};
          4'd6:    rdata = {2'd0, cap_f1[c]};
          4'd7:    rdata = {1'b0, cap_tot[c]};
          4'd8:    rdata = 16'(vid_std[c*STD_WIDTH +: STD_WIDTH]);
          4'd9:    rdata = {8'd0, cnt[c]};
          default: rdata = '0;
        endcase
      end
    end
    if (ch == CHW'(N)) begin
      case (rg)
        4'd0:    rdata = 16'(pend_chg | pend_stb);
        4'd1:    rdata = 16'(N);
        default: rdata = '0;
      endcase
    end
  end
endmodule

// File: doc/vid2is_mc_control.md
Name: vid2is_mc_control

Overview:
Multi-channel control/status register bank for the clocked-video-input-to-ImageStream path. Serves NUM_CHANNELS independent Vid2IS channels from one Avalon-MM slave with per-channel register pages plus a global page. Captures per-channel resolution-detector results on toggle-handshake updates, with a freeze option. Generates maskable, write-1-to-clear interrupts, per-channel resolution-change counters, and one combined IRQ.

Parameters:
NUM_CHANNELS, 2, number of channels (1..8)
USED_WORDS_WIDTH, 15, FIFO fill-level width per channel (<=16)
STD_WIDTH, 3, video-standard width per channel (<=16)
H_ACTIVE_PIXELS, 1920, reset value of captured active samples
V_ACTIVE_LINES_F0, 540, reset value of captured F0 lines
V_ACTIVE_LINES_F1, 540, reset value of captured F1 lines (used only if INTERLACED)
INTERLACED, 1, reset value of captured interlaced flag
CHW, 4, channel-select address bits (2^CHW > NUM_CHANNELS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
usedw  in  N*USED_WORDS_WIDTH  FIFO fill per channel
overflow_sticky  in  N  FIFO overflow flag per channel
is_output_enable  in  N  outgoing state-machine enable status
update  in  N  toggle: new detector results valid
resolution_change  in  N  toggle: resolution changed
stable, interlaced, resolution_valid  in  N each  detector flags
active_sample_count  in  N*15  detector active samples
active_line_count_f0  in  N*14  detector F0 lines
active_line_count_f1  in  N*14  detector F1 lines
total_sample_count  in  N*15  detector total samples
vid_std  in  N*STD_WIDTH  incoming video standard
av_address  in  CHW+4  {channel, register}
av_read, av_write  in  1  Avalon strobes
av_writedata  in  16  write data
av_readdata  out  16  read data
av_readdatavalid  out  1  read data valid
enable  out  N  per-channel output enable
clear_overflow_sticky  out  N  overflow-clear request
is_interlaced  out  N  captured interlaced
is_active_sample_count  out  N*15  captured active samples
is_active_line_count_f0  out  N*14  captured F0 lines
is_active_line_count_f1  out  N*14  captured F1 lines
irq  out  1  OR of all enabled pending interrupts

Behaviour:
- Reset (rst high at clk edge): enable=0, control regs=0, pending=0, counters=0, clear_overflow_sticky=0, av_readdatavalid=0, av_readdata=0, captured stable/valid/total=0, is_interlaced=INTERLACED, active samples=H_ACTIVE_PIXELS, F0=V_ACTIVE_LINES_F0, F1=INTERLACED?V_ACTIVE_LINES_F1:0. Toggle-history regs load current update/resolution_change, so no spurious edge after reset.
- Edge detect: per channel, edge = input XOR its 1-cycle-delayed copy. A one-cycle toggle gives exactly one edge.
- Per-channel page (channel<NUM_CHANNELS), register offsets:
  0 control RW: b0 enable, b1 change IE, b2 stable IE, b3 freeze.
  1 status RO: b0 is_output_enable, b1 captured stable, b2 is_interlaced, b3 captured valid, b4 overflow_sticky. Writing b4=1 requests overflow clear.
  2 interrupt: b1 change pending, b2 stable pending. Write-1-to-clear.
  3 usedw, zero-extended.
  4 active samples; 5 F0 lines; 6 F1 lines; 7 total samples (zero-extended).
  8 vid_std, zero-extended.
  9 change counter, 8-bit. Any write clears it.
- Global page (channel==NUM_CHANNELS): 0 irq bitmap, bit c = channel c has any pending; 1 = NUM_CHANNELS. All unmapped addresses read 0; writes to them are ignored.
- Read latency: av_readdata registered, valid with av_readdatavalid exactly 1 cycle after av_read. Back-to-back reads are supported, one per cycle.
- Capture: on update edge with freeze=0, all captured fields load next cycle. With freeze=1, the edge sets a deferred flag. When freeze clears, the capture is taken from the current inputs on the following cycle and the flag clears. Multiple edges while frozen produce one capture.
- Change pending: set on resolution_change edge when IE b1=1. Stable pending: set when captured stable changes value while IE b2=1. Clearing an IE bit clears its pending bit. Set beats W1C in the same cycle.
- Counter: increments on each resolution_change edge regardless of IE. Saturates at 255. Clear and increment in the same cycle yields 1.
- clear_overflow_sticky[c]: next = (write reg1 b4=1 | current) & overflow_sticky[c]. It holds until the FIFO drops overflow, and never asserts if overflow is already 0.
- irq is combinational OR of all pending bits.
- A write and a read in the same cycle to the same register returns the pre-write value.

Test Plan:
- Reset then read ch0 reg4, reg5, reg6 -> 1920, 540, 540 one cycle after av_read; global reg1 -> 2.
- Ch1 update toggle with active_sample_count=1280 -> ch1 reg4 reads 1280; ch0 reg4 still 1920.
- Ch0 freeze=1, two update toggles (720 then 640), freeze=0 -> single capture of 640 one cycle after unfreeze; no capture while frozen.
- Ch0 IE b1=1, resolution_change toggle -> irq=1, global reg0=0x0001; W1C 0x0002 to reg2 -> irq=0; counter reads 1.
- 300 resolution_change toggles -> counter reads 255; write reg9 in the same cycle as a toggle -> reads 1.
- overflow_sticky[1]=1, write ch1 reg1=0x0010 -> clear_overflow_sticky[1]=1 until overflow drops, then 0; repeat with overflow=0 -> stays 0.
